// File: rtl/uart_rx.sv
// UART receive engine: 2-flop synchronised rx, tick-driven oversampling FSM, valid/ack byte output.
// Optional parity stage between DATA and STOP is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] dout_o,
   output logic                 dout_vld_o,
   input  logic                 dout_ack_i,
   output logic                 rx_busy_o,
   output logic                 frame_err_o,
   output logic                 overrun_err_o,
   output logic                 parity_err_o
);

   localparam int unsigned SW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0) || (DATA_BITS < 2) || (PARITY_ODD > 1))
   begin : g_param_check
      $error("uart_rx: unsupported parameter combination");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_BREAK
   } state_t;

   logic                 rx_meta_q;
   logic                 rx_s_q;
   state_t               state_q, state_d;
   logic [SW-1:0]        sctr_q, sctr_d;
   logic [BW-1:0]        bctr_q, bctr_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 deliver;
   logic                 frame_err_d;
   logic                 frame_err_q;
   logic                 overrun_err_d;
   logic                 overrun_err_q;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 dout_vld_q, dout_vld_d;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = 1'(PARITY_ODD);
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_d;
   logic                 parity_err_q;
`endif

   // Both synchroniser flops reset to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sctr_q  <= '0;
         bctr_q  <= '0;
         shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sctr_q  <= sctr_d;
         bctr_q  <= bctr_d;
         shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      sctr_d      = sctr_q;
      bctr_d      = bctr_q;
      shreg_d     = shreg_q;
      deliver     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      if (tick_i) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s_q) begin
                  state_d = ST_START;
                  sctr_d  = '0;
               end
            end
            ST_START: begin
               if (sctr_q == S_HALF) begin
                  sctr_d = '0;
                  if (!rx_s_q) begin
                     state_d = ST_DATA;
                     bctr_d  = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  sctr_d = sctr_q + SW'(1);
               end
            end
            ST_DATA: begin
               if (sctr_q == S_LAST) begin
                  sctr_d  = '0;
                  shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                  if (bctr_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     bctr_d = bctr_q + BW'(1);
                  end
               end else begin
                  sctr_d = sctr_q + SW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (sctr_q == S_LAST) begin
                  sctr_d    = '0;
                  par_bad_d = rx_s_q ^ (^shreg_q) ^ PAR_ODD;
                  state_d   = ST_STOP;
               end else begin
                  sctr_d = sctr_q + SW'(1);
               end
            end
`endif
            ST_STOP: begin
               if (sctr_q == S_LAST) begin
                  sctr_d = '0;
                  if (rx_s_q) begin
                     state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     // A bad parity bit only reports once the stop bit is known to be good.
                     if (par_bad_q) parity_err_d = 1'b1;
                     else           deliver      = 1'b1;
`else
                     deliver = 1'b1;
`endif
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_BREAK;
                  end
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
`endif
               end else begin
                  sctr_d = sctr_q + SW'(1);
               end
            end
            ST_BREAK: begin
               if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dout_d        = dout_q;
      dout_vld_d    = dout_vld_q;
      overrun_err_d = 1'b0;
      if (dout_vld_q && dout_ack_i) dout_vld_d = 1'b0;
      // An ack in the delivery cycle frees the holding register for the new byte.
      if (deliver) begin
         if (!dout_vld_q || dout_ack_i) begin
            dout_d     = shreg_q;
            dout_vld_d = 1'b1;
         end else begin
            overrun_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q        <= '0;
         dout_vld_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q  <= 1'b0;
`endif
      end else begin
         dout_q        <= dout_d;
         dout_vld_q    <= dout_vld_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   assign dout_o        = dout_q;
   assign dout_vld_o    = dout_vld_q;
   assign rx_busy_o     = (state_q != ST_IDLE);
   assign frame_err_o   = frame_err_q;
   assign overrun_err_o = overrun_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err_o  = parity_err_q;
`else
   assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: OVERSAMPLE=16, one tick every 4 clk, 64 clk per serial bit.
module tb_uart_rx;
   localparam int BIT_CLK = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_i;
   logic       rx_i;
   logic       dout_ack_i;
   logic [7:0] dout_o;
   logic       dout_vld_o;
   logic       rx_busy_o;
   logic       frame_err_o;
   logic       overrun_err_o;
   logic       parity_err_o;

   logic [31:0] cyc = 32'd0;
   int n_checks = 0;
   int n_errors = 0;
   int ferr_cnt = 0;
   int oerr_cnt = 0;
   int perr_cnt = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_vld;
      int         exp_ferr;
   } vec_t;
   vec_t vecs[6];

   uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_ODD(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick_i),
      .rx_i         (rx_i),
      .dout_o       (dout_o),
      .dout_vld_o   (dout_vld_o),
      .dout_ack_i   (dout_ack_i),
      .rx_busy_o    (rx_busy_o),
      .frame_err_o  (frame_err_o),
      .overrun_err_o(overrun_err_o),
      .parity_err_o (parity_err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;
   assign tick_i = (cyc[1:0] == 2'd0);

   // Error pulses are counted in high cycles, so a stuck flag shows up as a count above one.
   always @(negedge clk) begin
      if (frame_err_o)   ferr_cnt <= ferr_cnt + 1;
      if (overrun_err_o) oerr_cnt <= oerr_cnt + 1;
      if (parity_err_o)  perr_cnt <= perr_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_compare(input string name, input logic [7:0] act);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: byte 0x%02h delivered with empty scoreboard", name, act);
      end else begin
         e = exp_q.pop_front();
         $display("rx byte %s: got 0x%02h expected 0x%02h", name, act, e);
         check(name, {24'd0, act}, {24'd0, e});
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_i = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   // Start bit, data bits LSB first and (when built in) the parity bit; the stop bit is run_stop's job.
   task automatic send_head(input logic [7:0] d, input logic par_flip);
      while (cyc[1:0] != 2'd0) @(negedge clk);
      $display("tx byte 0x%02h parity_flip=%0b", d, par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ par_flip);
`endif
   endtask

   // ack_mode 0: never ack; 1: ack 2 clk after dout_vld seen; 2: ack raised at negedge ack_k.
   task automatic run_stop(input logic stop_val, input int ack_mode, input int ack_k,
                           output int vld_k, output logic [7:0] dout_cap,
                           output logic vld_after, output logic [7:0] dout_after);
      int ack_raised;
      ack_raised = 0;
      vld_k      = 0;
      dout_cap   = 8'h00;
      vld_after  = 1'b0;
      dout_after = 8'h00;
      rx_i = stop_val;
      for (int k = 1; k <= 96; k++) begin
         @(negedge clk);
         dout_ack_i = 1'b0;
         if (ack_raised != 0 && k == ack_raised + 1) begin
            vld_after  = dout_vld_o;
            dout_after = dout_o;
         end
         if (vld_k == 0 && dout_vld_o) begin
            vld_k    = k;
            dout_cap = dout_o;
         end
         if ((ack_mode == 1 && vld_k != 0 && k == vld_k + 2) || (ack_mode == 2 && k == ack_k)) begin
            dout_ack_i = 1'b1;
            ack_raised = k;
         end
      end
      dout_ack_i = 1'b0;
      if (!stop_val) begin
         rx_i = 1'b1;
         repeat (BIT_CLK) @(negedge clk);
      end
   endtask

   initial begin
      int         vk;
      int         lat;
      int         f0, o0, p0;
      logic [7:0] dc, da;
      logic       va;
      logic       seen;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1};
      vecs[2] = '{8'h55, 1'b1, 1'b1, 0};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 0};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 0};
      vecs[5] = '{8'h81, 1'b1, 1'b1, 0};

      rst = 1'b1;
      rx_i = 1'b1;
      dout_ack_i = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_dout", {24'd0, dout_o}, 32'd0);
      check("reset_flags", {26'd0, dout_vld_o, rx_busy_o, frame_err_o, overrun_err_o, parity_err_o, 1'b0}, 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      foreach (vecs[i]) begin
         f0 = ferr_cnt; o0 = oerr_cnt; p0 = perr_cnt;
         if (vecs[i].exp_vld) exp_q.push_back(vecs[i].data);
         send_head(vecs[i].data, 1'b0);
         run_stop(vecs[i].stop, 1, 0, vk, dc, va, da);
         check($sformatf("vec%0d_vld_seen", i), {31'd0, vk != 0}, {31'd0, vecs[i].exp_vld});
         if (vecs[i].exp_vld) begin
            if (vk != 0) sb_compare($sformatf("vec%0d_dout", i), dc);
            else void'(exp_q.pop_front());
            check($sformatf("vec%0d_vld_cleared", i), {31'd0, va}, 32'd0);
         end
         check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_ferr);
         check($sformatf("vec%0d_overrun", i), oerr_cnt - o0, 32'd0);
         check($sformatf("vec%0d_parity", i), perr_cnt - p0, 32'd0);
         check($sformatf("vec%0d_idle", i), {31'd0, rx_busy_o}, 32'd0);
      end

      // Four-tick low glitch must be rejected at the mid-start check.
      f0 = ferr_cnt;
      seen = 1'b0;
      while (cyc[1:0] != 2'd0) @(negedge clk);
      rx_i = 1'b0;
      repeat (16) @(negedge clk);
      rx_i = 1'b1;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (dout_vld_o) seen = 1'b1;
      end
      $display("glitch: vld_seen=%0b busy=%0b", seen, rx_busy_o);
      check("glitch_no_vld", {31'd0, seen}, 32'd0);
      check("glitch_idle", {31'd0, rx_busy_o}, 32'd0);
      check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

      // Overrun: second byte arrives while the first is still unacknowledged.
      exp_q.push_back(8'h11);
      send_head(8'h11, 1'b0);
      run_stop(1'b1, 0, 0, vk, dc, va, da);
      lat = vk;
      check("ovr_first_seen", {31'd0, vk != 0}, 32'd1);
      if (vk != 0) sb_compare("ovr_first", dc);
      else void'(exp_q.pop_front());
      o0 = oerr_cnt;
      send_head(8'h22, 1'b0);
      run_stop(1'b1, 0, 0, vk, dc, va, da);
      check("ovr_pulse", oerr_cnt - o0, 32'd1);
      check("ovr_dout_kept", {24'd0, dout_o}, 32'h11);
      check("ovr_vld_held", {31'd0, dout_vld_o}, 32'd1);
      dout_ack_i = 1'b1;
      @(negedge clk);
      dout_ack_i = 1'b0;
      check("ovr_ack_clears", {31'd0, dout_vld_o}, 32'd0);

      // Ack landing on the delivery cycle lets the new byte replace the old one.
      exp_q.push_back(8'h33);
      send_head(8'h33, 1'b0);
      run_stop(1'b1, 0, 0, vk, dc, va, da);
      if (vk != 0) sb_compare("same_cycle_first", dc);
      else begin
         void'(exp_q.pop_front());
         check("same_cycle_first_seen", 32'd0, 32'd1);
      end
      o0 = oerr_cnt;
      exp_q.push_back(8'h22);
      send_head(8'h22, 1'b0);
      run_stop(1'b1, 2, lat - 1, vk, dc, va, da);
      sb_compare("same_cycle_dout", da);
      check("same_cycle_vld", {31'd0, va}, 32'd1);
      check("same_cycle_no_ovr", oerr_cnt - o0, 32'd0);
      dout_ack_i = 1'b1;
      @(negedge clk);
      dout_ack_i = 1'b0;
      check("same_cycle_ack_clears", {31'd0, dout_vld_o}, 32'd0);

      // Reset in the middle of a data bit while a byte is still held.
      exp_q.push_back(8'h5A);
      send_head(8'h5A, 1'b0);
      run_stop(1'b1, 0, 0, vk, dc, va, da);
      if (vk != 0) sb_compare("pre_reset", dc);
      else begin
         void'(exp_q.pop_front());
         check("pre_reset_seen", 32'd0, 32'd1);
      end
      while (cyc[1:0] != 2'd0) @(negedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b0);
      rx_i = 1'b1;
      repeat (BIT_CLK / 2) @(negedge clk);
      check("mid_busy_before_rst", {31'd0, rx_busy_o}, 32'd1);
      rst = 1'b1;
      #1;
      $display("reset mid-frame: dout=0x%02h vld=%0b busy=%0b", dout_o, dout_vld_o, rx_busy_o);
      check("mid_rst_dout", {24'd0, dout_o}, 32'd0);
      check("mid_rst_vld", {31'd0, dout_vld_o}, 32'd0);
      check("mid_rst_busy", {31'd0, rx_busy_o}, 32'd0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      exp_q.push_back(8'h0F);
      send_head(8'h0F, 1'b0);
      run_stop(1'b1, 1, 0, vk, dc, va, da);
      check("post_rst_seen", {31'd0, vk != 0}, 32'd1);
      if (vk != 0) sb_compare("post_rst", dc);
      else void'(exp_q.pop_front());

`ifdef UART_RX_PARITY_EN
      p0 = perr_cnt;
      exp_q.push_back(8'h07);
      send_head(8'h07, 1'b0);
      run_stop(1'b1, 1, 0, vk, dc, va, da);
      check("par_ok_seen", {31'd0, vk != 0}, 32'd1);
      if (vk != 0) sb_compare("par_ok", dc);
      else void'(exp_q.pop_front());
      check("par_ok_no_err", perr_cnt - p0, 32'd0);
      f0 = ferr_cnt;
      send_head(8'h07, 1'b1);
      run_stop(1'b1, 1, 0, vk, dc, va, da);
      check("par_bad_no_vld", {31'd0, vk != 0}, 32'd0);
      check("par_bad_pulse", perr_cnt - p0, 32'd1);
      check("par_bad_no_ferr", ferr_cnt - f0, 32'd0);
`else
      check("parity_err_never", perr_cnt, 32'd0);
`endif

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
